// File: rtl/snn_config_loader.sv
// Byte-stream configuration loader for the 3-neuron spiking layer: shadows a frame, then commits it atomically.
// Optional checksum byte and cfg_err flag enabled by defining SNN_CFG_CHECKSUM_EN.
module snn_config_loader #(
   parameter int unsigned NUM_WEIGHT_BYTES = 9,
   parameter int unsigned NUM_PARAM_BYTES  = 4,
   parameter int unsigned DATA_W           = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               load_strobe,
   input  logic [DATA_W-1:0]                  data_in,
   input  logic                               run_en,
   output logic [NUM_WEIGHT_BYTES*DATA_W-1:0] input_weights,
   output logic [NUM_PARAM_BYTES*DATA_W-1:0]  neuron_params,
   output logic                               layer_enable,
   output logic                               cfg_valid,
   output logic                               commit_pulse,
   output logic                               busy,
   output logic [3:0]                         byte_idx,
   output logic                               cfg_err
);

   localparam int unsigned W_W        = NUM_WEIGHT_BYTES * DATA_W;
   localparam int unsigned P_W        = NUM_PARAM_BYTES * DATA_W;
   localparam int unsigned DATA_BYTES = NUM_WEIGHT_BYTES + NUM_PARAM_BYTES;
   localparam int unsigned IDX_W      = 4;
`ifdef SNN_CFG_CHECKSUM_EN
   localparam int unsigned FRAME_LEN  = DATA_BYTES + 1;
`else
   localparam int unsigned FRAME_LEN  = DATA_BYTES;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   byte_idx_nxt;
   logic               strobe_q;
   logic               stb_edge_c;
   logic               wr_byte;
   logic               do_commit;
   logic               ck_ok_c;
   logic [DATA_W-1:0]  shadow [DATA_BYTES];
   logic [W_W-1:0]     weights_c;
   logic [P_W-1:0]     params_c;

   assign stb_edge_c   = load_strobe & ~strobe_q;
   assign busy         = (state != IDLE);
   assign layer_enable = cfg_valid & run_en;

   // Next-state and datapath control
   always_comb begin
      state_nxt    = state;
      byte_idx_nxt = byte_idx;
      wr_byte      = 1'b0;
      do_commit    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = LOAD;
               byte_idx_nxt = '0;
            end
         end
         LOAD: begin
            if (start) begin
               byte_idx_nxt = '0;
            end else if (stb_edge_c) begin
               wr_byte      = 1'b1;
               byte_idx_nxt = byte_idx + IDX_W'(1);
               if (byte_idx == IDX_W'(FRAME_LEN - 1)) state_nxt = COMMIT;
            end
         end
         COMMIT: begin
            state_nxt    = IDLE;
            byte_idx_nxt = '0;
            do_commit    = ck_ok_c;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         byte_idx <= '0;
         strobe_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         byte_idx <= byte_idx_nxt;
         strobe_q <= load_strobe;
      end
   end

   // Shadow capture; the checksum byte (if any) never lands here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < DATA_BYTES; k++) shadow[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            if (wr_byte && byte_idx == IDX_W'(k)) shadow[k] <= data_in;
         end
      end
   end

   // Byte 0 lands in the most significant lane of each field
   always_comb begin
      weights_c = '0;
      params_c  = '0;
      for (int unsigned k = 0; k < NUM_WEIGHT_BYTES; k++)
         weights_c[W_W-1-DATA_W*k -: DATA_W] = shadow[k];
      for (int unsigned k = 0; k < NUM_PARAM_BYTES; k++)
         params_c[P_W-1-DATA_W*k -: DATA_W] = shadow[NUM_WEIGHT_BYTES+k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         input_weights <= '0;
         neuron_params <= '0;
         cfg_valid     <= 1'b0;
         commit_pulse  <= 1'b0;
      end else begin
         commit_pulse <= do_commit;
         if (do_commit) begin
            input_weights <= weights_c;
            neuron_params <= params_c;
            cfg_valid     <= 1'b1;
         end
      end
   end

`ifdef SNN_CFG_CHECKSUM_EN
   logic              clr_frame_c;
   logic              ck_fail_c;
   logic [DATA_W-1:0] xor_acc;

   // XOR over data and checksum bytes is zero for a good frame
   assign clr_frame_c = start && (state != COMMIT);
   assign ck_ok_c     = (xor_acc == '0);
   assign ck_fail_c   = (state == COMMIT) && !ck_ok_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xor_acc <= '0;
         cfg_err <= 1'b0;
      end else begin
         if (clr_frame_c)  xor_acc <= '0;
         else if (wr_byte) xor_acc <= xor_acc ^ data_in;
         if (clr_frame_c)    cfg_err <= 1'b0;
         else if (ck_fail_c) cfg_err <= 1'b1;
         else if (do_commit) cfg_err <= 1'b0;
      end
   end
`else
   assign ck_ok_c = 1'b1;
   assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_config_loader.sv
// Randomized self-checking bench for snn_config_loader against a frame-level reference model.
module tb_snn_config_loader;

   localparam int unsigned NWB = 9;
   localparam int unsigned NDB = 13;
`ifdef SNN_CFG_CHECKSUM_EN
   localparam int unsigned FLEN = 14;
`else
   localparam int unsigned FLEN = 13;
`endif

   logic        clk, rst_n, start, load_strobe, run_en;
   logic [7:0]  data_in;
   logic [71:0] input_weights;
   logic [31:0] neuron_params;
   logic        layer_enable, cfg_valid, commit_pulse, busy, cfg_err;
   logic [3:0]  byte_idx;

   snn_config_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .load_strobe(load_strobe),
      .data_in(data_in), .run_en(run_en), .input_weights(input_weights),
      .neuron_params(neuron_params), .layer_enable(layer_enable),
      .cfg_valid(cfg_valid), .commit_pulse(commit_pulse), .busy(busy),
      .byte_idx(byte_idx), .cfg_err(cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;
   int pulse_cnt = 0;

   always @(negedge clk) if (commit_pulse) pulse_cnt++;

   // Reference model: frame-level view of what the loader holds
   bit          m_load;
   int          m_n;
   logic [7:0]  m_buf [FLEN];
   logic [71:0] m_w;
   logic [31:0] m_p;
   bit          m_valid, m_err;
   logic [7:0]  fbuf [FLEN];

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit frame_ok();
`ifdef SNN_CFG_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      for (int k = 0; k < int'(NDB); k++) x ^= m_buf[k];
      return x == m_buf[NDB];
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      m_load = 0; m_n = 0; m_w = '0; m_p = '0; m_valid = 0; m_err = 0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ":idx"},   72'(byte_idx),      72'(m_load ? m_n : 0));
      check({tag, ":busy"},  72'(busy),          72'(m_load));
      check({tag, ":w"},     input_weights,      m_w);
      check({tag, ":p"},     72'(neuron_params), 72'(m_p));
      check({tag, ":valid"}, 72'(cfg_valid),     72'(m_valid));
      check({tag, ":en"},    72'(layer_enable),  72'(m_valid & run_en));
      check({tag, ":err"},   72'(cfg_err),       72'(m_err));
   endtask

   // One strobe held `hold` cycles then released; watches for the commit pulse
   task automatic send_byte(input logic [7:0] d, input int hold);
      bit last, ok;
      last = m_load && (m_n == int'(FLEN) - 1);
      ok   = 0;
      if (m_load) begin
         m_buf[m_n] = d;
         m_n++;
      end
      if (last) begin
         ok = frame_ok();
         m_load = 0;
         m_n = 0;
         if (ok) begin
            m_w = '0;
            m_p = '0;
            for (int k = 0; k < int'(NWB); k++) m_w = (m_w << 8) | 72'(m_buf[k]);
            for (int k = int'(NWB); k < int'(NDB); k++) m_p = (m_p << 8) | 32'(m_buf[k]);
            m_valid = 1;
            m_err = 0;
         end else begin
            m_err = 1;
         end
      end
      load_strobe = 1'b1;
      data_in = d;
      for (int i = 1; i <= hold + 2; i++) begin
         @(negedge clk);
         if (i == hold) load_strobe = 1'b0;
         check("commit_pulse", 72'(commit_pulse), 72'(last && ok && i == 2));
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_load = 1; m_n = 0; m_err = 0;
   endtask

   task automatic start_with_byte(input logic [7:0] d);
      start = 1'b1;
      load_strobe = 1'b1;
      data_in = d;
      @(negedge clk);
      start = 1'b0;
      load_strobe = 1'b0;
      @(negedge clk);
      m_load = 1; m_n = 0; m_err = 0;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst:w",     input_weights,      72'h0);
      check("rst:p",     72'(neuron_params), 72'h0);
      check("rst:valid", 72'(cfg_valid),     72'h0);
      check("rst:en",    72'(layer_enable),  72'h0);
      check("rst:idx",   72'(byte_idx),      72'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic fix_ck();
`ifdef SNN_CFG_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      for (int k = 0; k < int'(NDB); k++) x ^= fbuf[k];
      fbuf[NDB] = x;
`endif
   endtask

   task automatic gen_frame(input bit good);
      for (int k = 0; k < int'(NDB); k++) fbuf[k] = 8'($urandom);
      fix_ck();
`ifdef SNN_CFG_CHECKSUM_EN
      if (!good) fbuf[NDB] = fbuf[NDB] ^ 8'($urandom_range(1, 255));
`endif
   endtask

   task automatic send_fbuf(input int max_hold);
      do_start();
      for (int k = 0; k < int'(FLEN); k++) send_byte(fbuf[k], $urandom_range(1, max_hold));
   endtask

   logic [71:0] w_a;
   int          p0;

   initial begin
      rst_n = 1'b0; start = 1'b0; load_strobe = 1'b0; data_in = 8'h00; run_en = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Strobes while idle before any frame are ignored
      for (int k = 0; k < 3; k++) send_byte(8'hA5, 1);
      check_state("idle_stray");

      // Known frame 0x01..0x0D
      for (int k = 0; k < int'(NDB); k++) fbuf[k] = 8'(k + 1);
`ifdef SNN_CFG_CHECKSUM_EN
      fbuf[NDB] = 8'h01;
`endif
      send_fbuf(1);
      check("seq:w",     input_weights,      72'h010203040506070809);
      check("seq:p",     72'(neuron_params), 72'h0A0B0C0D);
      check("seq:en",    72'(layer_enable),  72'h1);
      check("seq:pulses", 72'(pulse_cnt),    72'h1);
      check_state("seq");

      // Held strobe writes one byte only
      gen_frame(1);
      fbuf[0] = 8'h55;
      fbuf[1] = 8'h66;
      fix_ck();
      do_start();
      send_byte(fbuf[0], 5);
      send_byte(fbuf[1], 1);
      check("hold:idx", 72'(byte_idx), 72'h2);
      for (int k = 2; k < int'(FLEN); k++) send_byte(fbuf[k], $urandom_range(1, 3));
      check("hold:w_top", 72'(input_weights[71:56]), 72'h5566);
      check_state("hold");

      // Frame A, aborted frame B, frame C
      p0 = pulse_cnt;
      gen_frame(1);
      send_fbuf(3);
      w_a = m_w;
      do_start();
      for (int k = 0; k < 7; k++) send_byte(8'($urandom), $urandom_range(1, 3));
      check("abort:w_a", input_weights, w_a);
      gen_frame(1);
      send_fbuf(3);
      check("abort:pulses", 72'(pulse_cnt - p0), 72'h2);
      check_state("abort");

      // Reset in the middle of a frame, then a full reload
      do_start();
      for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1);
      do_reset();
      check_state("midrst");
      gen_frame(1);
      send_fbuf(2);
      check_state("midrst_reload");

`ifdef SNN_CFG_CHECKSUM_EN
      for (int k = 0; k < int'(NDB); k++) fbuf[k] = 8'(k + 1);
      fbuf[NDB] = 8'h01;
      send_fbuf(1);
      check("ck_good:w", input_weights, 72'h010203040506070809);
      w_a = input_weights;
      fbuf[NDB] = 8'h00;
      p0 = pulse_cnt;
      send_fbuf(1);
      check("ck_bad:err",    72'(cfg_err),          72'h1);
      check("ck_bad:pulses", 72'(pulse_cnt - p0),   72'h0);
      check("ck_bad:w",      input_weights,         72'h010203040506070809);
      do_start();
      check("ck_clr:err",    72'(cfg_err),          72'h0);
      check_state("ck");
`endif

      // Randomized mix of frames, aborts, stray strobes, resets
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: begin
               gen_frame($urandom_range(0, 5) != 0);
               send_fbuf(4);
            end
            3: begin
               do_start();
               for (int k = 0; k < int'($urandom_range(0, FLEN - 1)); k++)
                  send_byte(8'($urandom), $urandom_range(1, 4));
            end
            4: for (int k = 0; k < int'($urandom_range(1, 2)); k++) send_byte(8'($urandom), 1);
            5: start_with_byte(8'($urandom));
            6: begin
               run_en = 1'($urandom);
               repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            7: if ($urandom_range(0, 3) == 0) begin
               run_en = 1'b1;
               do_reset();
            end
            default: send_byte(8'($urandom), $urandom_range(1, 6));
         endcase
         check_state("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
